booth_muler: RTL and testbench
==============================

Name: booth_muler

Overview:
- Sequential radix-2 Booth multiplier for signed two's-complement operands.
- Sits directly upstream of the signed add/sub adder and drives it: each iteration presents the partial-product high half and the multiplicand, and selects add or subtract from the Booth pair.
- Multi-cycle, with a valid/ready handshake on both input and output. Intended as the core of the muler project.

Parameters:
- N, 8, operand width in bits. Signed; N >= 2. Product width is 2N.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- a  input  N  multiplicand, signed; sampled only on input handshake
- b  input  N  multiplier, signed; sampled only on input handshake
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- p  output  2N  signed product a*b

Behaviour:
- Internal registers:
  - A, N+1 bits: accumulator (high half).
  - Q, N bits: multiplier, low half.
  - q_1, 1 bit: Booth guard bit.
  - M, N+1 bits: sign-extended multiplicand.
  - cnt, counts 0..N-1.
  - state: IDLE, CALC, DONE.
- Add/sub is performed by one instance of the team's signed add/sub adder with n = N+1:
  - a = A, b = M.
  - add_sub = 1 for subtract.
  - Its carry, zero and overflow outputs are unused.
- Reset (rst=1 at an edge): state=IDLE, A=0, Q=0, q_1=0, M=0, cnt=0. Outputs: in_ready=1, out_valid=0, p=0.
- Reset mid-operation (CALC or DONE): any in-flight result is discarded. Next cycle is IDLE with the values above. No output handshake occurs.
- IDLE:
  - in_ready=1, out_valid=0.
  - On the edge where in_valid && in_ready: A=0, Q=b, q_1=0, M={a[N-1],a}, cnt=0, state=CALC.
  - With in_valid=0, state holds.
- CALC:
  - in_ready=0, out_valid=0.
  - Each edge, Booth step on {Q[0],q_1}:
    - 01: A' = A+M.
    - 10: A' = A-M.
    - 00/11: A' = A.
  - Then arithmetic right shift of {A',Q,q_1} by 1. The MSB of A' is replicated into the new A MSB.
  - cnt increments. On the edge where cnt==N-1, state=DONE.
  - Exactly N CALC cycles per operation.
- DONE:
  - out_valid=1, in_ready=0.
  - p = {A[N-1:0],Q}, registered and stable while out_valid=1 && out_ready=0.
  - On the edge with out_ready=1: state=IDLE. A new input is not accepted in that same cycle.
- Latency: input handshake at the edge ending cycle 0; out_valid first high in cycle N+1. Throughput is one product per N+2 cycles minimum.
- Width rules:
  - The N+1-bit accumulator makes -M representable for a = -2^(N-1).
  - The product always fits in 2N bits, so the result never overflows.
- p holds its last value outside DONE and is not cleared after the handshake. Only reset clears it.
- in_valid/out_ready asserted in wrong states are ignored, with no side effects.

Test Plan:
- Reset, then a=3, b=5 with in_valid=1, out_ready=1 -> in_ready drops the cycle after handshake; out_valid=1 in cycle 9 with p=16'h000F; back to IDLE after one cycle.
- a=-128 (8'h80), b=-128 -> p=16'h4000. Checks the extended accumulator for negation of the most-negative value.
- a=-128, b=127 -> p=16'hC080. a=-1, b=-1 -> p=16'h0001. a=0, b=8'h5A -> p=16'h0000.
- a=7, b=-3 with out_ready held 0 for 5 cycles after out_valid -> out_valid stays 1 and p=16'hFFEB stable throughout. in_valid=1 during this window is not accepted. Result is accepted on the first out_ready=1 edge.
- Assert rst for one cycle at CALC cycle 4 of a=25, b=9 -> next cycle IDLE, in_ready=1, out_valid=0, p=0. Then a=25, b=9 -> p=16'h00E1.
- Back-to-back: in_valid held 1 with operand pairs (2,3) then (-4,6), out_ready=1 -> products 16'h0006 then 16'hFFE8. Second input is accepted only after returning to IDLE; spacing between out_valid pulses is N+2 cycles.

Source files
------------

// File: rtl/booth_muler.sv
// Sequential radix-2 Booth multiplier (signed N x N -> 2N); product valid N+1 cycles after input handshake.
// in_ready only in IDLE; product held in DONE until out_ready, then one IDLE cycle before the next accept.
module signed_add_sub #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         add_sub,
  output logic [n-1:0] sum,
  output logic         carry,
  output logic         zero,
  output logic         overflow
);
  logic [n-1:0] b_x;
  logic [n:0]   full;

  always_comb begin
    b_x      = add_sub ? ~b : b;
    full     = {1'b0, a} + {1'b0, b_x} + {{n{1'b0}}, add_sub};
    sum      = full[n-1:0];
    carry    = full[n];
    zero     = (full[n-1:0] == '0);
    overflow = (a[n-1] == b_x[n-1]) && (full[n-1] != a[n-1]);
  end
endmodule

module booth_muler #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [N:0]       acc_q, acc_d;
  logic [N-1:0]     q_q, q_d;
  logic             q_1_q, q_1_d;
  logic [N:0]       m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [2*N-1:0]   p_q, p_d;

  logic [1:0]       booth_pair;
  logic             do_sub;
  logic [N:0]       adder_sum;
  logic [N:0]       acc_step;
  logic [2*N+1:0]   shifted;
  logic             adder_unused_carry;
  logic             adder_unused_zero;
  logic             adder_unused_overflow;

  assign booth_pair = {q_q[0], q_1_q};
  assign do_sub     = (booth_pair == 2'b10);

  signed_add_sub #(.n(N + 1)) u_add_sub (
    .a        (acc_q),
    .b        (m_q),
    .add_sub  (do_sub),
    .sum      (adder_sum),
    .carry    (adder_unused_carry),
    .zero     (adder_unused_zero),
    .overflow (adder_unused_overflow)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    q_d         = q_q;
    q_1_d       = q_1_q;
    m_d         = m_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    p_d         = p_q;
    acc_step    = (booth_pair == 2'b01 || booth_pair == 2'b10) ? adder_sum : acc_q;
    // Arithmetic shift of {A', Q, q_1}: A' MSB replicated, q_1 falls off the end.
    shifted     = {acc_step[N], acc_step, q_q};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d      = '0;
          q_d        = b;
          q_1_d      = 1'b0;
          m_d        = {a[N-1], a};
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        {acc_d, q_d, q_1_d} = shifted;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          p_d         = shifted[2*N:1];
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      q_q         <= '0;
      q_1_q       <= 1'b0;
      m_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      p_q         <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      q_q         <= q_d;
      q_1_q       <= q_1_d;
      m_q         <= m_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = p_q;
endmodule

// File: tb/tb_booth_muler.sv
// Bench for booth_muler: directed vector table, handshake corner sequences and random products vs. integer model.
module tb_booth_muler;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] p;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_muler #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  typedef struct {
    logic [N-1:0]   va;
    logic [N-1:0]   vb;
    int             stall;
    logic [2*N-1:0] vp;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
    int xi;
    int yi;
    int r;
    xi = int'($signed(x));
    yi = int'($signed(y));
    r  = xi * yi;
    return r[2*N-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One full transaction; optionally holds out_ready low for `stall` cycles while offering junk input.
  task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input int stall,
                       input logic [2*N-1:0] exp, input string tag);
    int e;
    logic [2*N-1:0] held;
    a = ta;
    b = tb_v;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, " in_ready_drop"}, 64'(in_ready), 64'(0));
    e = 0;
    while (!out_valid && e < 4 * N) begin
      @(posedge clk); #1;
      e++;
    end
    chk({tag, " latency"}, 64'(e), 64'(N));
    chk({tag, " p"}, 64'(p), 64'(exp));
    held = p;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a = ~ta;
      b = ~tb_v;
      @(posedge clk); #1;
      chk({tag, " stall_valid"}, 64'(out_valid), 64'(1));
      chk({tag, " stall_p"}, 64'(p), 64'(held));
      chk({tag, " stall_in_ready"}, 64'(in_ready), 64'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " idle_valid"}, 64'(out_valid), 64'(0));
    chk({tag, " idle_ready"}, 64'(in_ready), 64'(1));
    chk({tag, " p_hold"}, 64'(p), 64'(held));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int nseen;
    int t[2];
    logic [2*N-1:0] pv[2];
    logic seen_valid;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    vecs[0] = '{8'd3,   8'd5,   0, 16'h000F};
    vecs[1] = '{8'h80,  8'h80,  0, 16'h4000};
    vecs[2] = '{8'h80,  8'h7F,  0, 16'hC080};
    vecs[3] = '{8'hFF,  8'hFF,  0, 16'h0001};
    vecs[4] = '{8'h00,  8'h5A,  0, 16'h0000};
    vecs[5] = '{8'd7,   8'hFD,  5, 16'hFFEB};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 64'(in_ready), 64'(1));
    chk("reset out_valid", 64'(out_valid), 64'(0));
    chk("reset p", 64'(p), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      do_op(vecs[i].va, vecs[i].vb, vecs[i].stall, vecs[i].vp, $sformatf("vec%0d", i));

    // Reset during CALC cycle 4 discards the operation.
    a = 8'd25; b = 8'd9; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst in_ready", 64'(in_ready), 64'(1));
    chk("midrst out_valid", 64'(out_valid), 64'(0));
    chk("midrst p", 64'(p), 64'(0));
    seen_valid = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    chk("midrst no_output", 64'(seen_valid), 64'(0));
    do_op(8'd25, 8'd9, 0, 16'h00E1, "after_rst");

    // Back-to-back with in_valid held high.
    cyc = 0; nseen = 0; t[0] = 0; t[1] = 0; pv[0] = '0; pv[1] = '0;
    a = 8'd2; b = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 8'hFC; b = 8'd6;
    while (nseen < 2 && cyc < 6 * N) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) begin
        t[nseen]  = cyc;
        pv[nseen] = p;
        nseen++;
        if (nseen == 2) in_valid = 1'b0;
      end
    end
    chk("b2b count", 64'(nseen), 64'(2));
    chk("b2b first_latency", 64'(t[0]), 64'(N));
    chk("b2b p0", 64'(pv[0]), 64'(16'h0006));
    chk("b2b p1", 64'(pv[1]), 64'(16'hFFE8));
    chk("b2b spacing", 64'(t[1] - t[0]), 64'(N + 2));
    @(posedge clk); #1;
    chk("b2b idle", 64'(in_ready), 64'(1));

    for (int i = 0; i < 40; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      do_op(ra, rb, int'($urandom_range(0, 2)), ref_mul(ra, rb), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
